// File: rtl/sync_fifo_rd_stream.sv
// Read-side stream adapter for sync_fifo: issues rd_en, captures dout into a
// 2-entry prefetch buffer, presents valid/ready. Define RD_STREAM_LAST_EN for out_last.
module sync_fifo_rd_stream #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       occupancy,
  output logic             err_overflow
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             infl_q, infl_d;
  logic             err_q, err_d;
  logic             pop, push;
  logic [2:0]       level;

  // Issue only if the word would still fit once everything already in flight
  // lands, counting this cycle's pop so streaming never stalls.
  always_comb begin
    pop        = (occ_q != 2'd0) && out_ready;
    push       = infl_q;
    level      = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    fifo_rd_en = !fifo_empty && !rst && (level < 3'd2);
    infl_d     = fifo_rd_en;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    err_d      = err_q;
    case ({push, pop})
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_dout;
        end else begin
          head_d = tail_q;
          tail_d = fifo_dout;
        end
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = fifo_dout;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = fifo_dout;
          occ_d  = 2'd2;
        end else begin
          err_d = 1'b1;
        end
      end
      2'b01: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
        end
        occ_d = occ_q - 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      infl_q <= infl_d;
      err_q  <= err_d;
    end
  end

  assign out_valid    = (occ_q != 2'd0);
  assign out_data     = head_q;
  assign occupancy    = occ_q;
  assign err_overflow = err_q;

`ifdef RD_STREAM_LAST_EN
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_last = out_valid && (cnt_q == LAST_BEAT);
`else
  assign out_last = 1'b0;
`endif

  // The issue rule keeps the buffer from ever overflowing.
  ovf_never: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (occ_q == 2'd2)));
  burst_len_ok: assert property (@(posedge clk) BURST_LEN >= 1);

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Bench for sync_fifo_rd_stream with a behavioural sync_fifo model upstream.
// Out_last expectations follow RD_STREAM_LAST_EN.
module tb_sync_fifo_rd_stream;

  localparam int WIDTH     = 32;
  localparam int BURST_LEN = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_empty = 1'b1;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       occupancy;
  logic             err_overflow;

  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;

  int total = 0;
  int bad   = 0;

  sync_fifo_rd_stream #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .occupancy    (occupancy),
    .err_overflow (err_overflow)
  );

  initial forever #5 clk = ~clk;

  // Upstream FIFO: registered dout and empty, shared reset, underflow counted.
  logic [WIDTH-1:0] fq[$];
  int uf_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_dout <= '0;
    end else begin
      if (fifo_rd_en) begin
        if (fq.size() == 0) uf_cnt++;
        else fifo_dout <= fq.pop_front();
      end
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_empty <= (fq.size() == 0);
  end

  logic [WIDTH-1:0] exp_q[$];
  bit sb_en = 1'b0;
  int cyc = 0;
  int first_rd = -1, first_valid = -1, first_pop = -1, last_pop = -1;
  int pops = 0, beat = 0, last_cnt = 0;

  typedef struct {
    logic             rst;
    logic             wr;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             exp_rd;
    logic             exp_valid;
    logic             chk_data;
    logic [WIDTH-1:0] exp_data;
    logic [1:0]       exp_occ;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic rdy);
    rst       = r;
    wr_en     = w;
    wr_data   = d;
    out_ready = rdy;
  endtask

  function automatic logic expLast(input int b);
`ifdef RD_STREAM_LAST_EN
    return (b % BURST_LEN) == (BURST_LEN - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle invariants plus the scoreboard; called at the falling edge.
  task automatic monitorCycle();
    cyc++;
    checkOutput("rd_en_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
    checkOutput("occupancy_max", {31'd0, occupancy <= 2'd2}, 32'd1);
    checkOutput("err_overflow", {31'd0, err_overflow}, 32'd0);
    if (rst) begin
      checkOutput("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
    end else begin
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (sb_en && out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_valid", 32'd1, 32'd0);
        end else begin
          checkOutput("out_data", out_data, exp_q[0]);
          checkOutput("out_last", {31'd0, out_last}, {31'd0, expLast(beat)});
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (out_last) last_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
            beat++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitorCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    beat = 0; pops = 0; last_cnt = 0;
    first_rd = -1; first_valid = -1; first_pop = -1; last_pop = -1;
  endtask

  task automatic writeWord(input logic [WIDTH-1:0] d, input logic rdy);
    applyStimulus(1'b0, 1'b1, d, rdy);
    exp_q.push_back(d);
    tick();
  endtask

  task automatic drain(input int budget, input bit toggle);
    int n;
    n = 0;
    wr_en = 1'b0;
    while (exp_q.size() > 0 && n < budget) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      n++;
    end
    checkOutput("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    // rst, wr, data, ready | rd, valid, chk, data, occ
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        2'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0};
    vecs[8]  = '{1'b0, 1'b1, 32'h2,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h1,        2'd1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};

    // Reset: held two cycles, everything at its reset value afterwards.
    doReset();
    checkOutput("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_data", out_data, 32'd0);
    checkOutput("reset_last", {31'd0, out_last}, 32'd0);
    checkOutput("reset_occ", {30'd0, occupancy}, 32'd0);

    // Single word then empty, followed by a reset that flushes a held word.
    sb_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].ready);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, vecs[i].exp_rd});
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d_occ", i), {30'd0, occupancy}, {30'd0, vecs[i].exp_occ});
      checkOutput($sformatf("vec%0d_last", i), {31'd0, out_last}, 32'd0);
      if (vecs[i].chk_data)
        checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      monitorCycle();
      @(posedge clk);
      #1;
    end
    sb_en = 1'b1;

    // Full-rate stream of 0..31.
    doReset();
    for (int i = 0; i < 32; i++) writeWord(i, 1'b1);
    drain(100, 1'b0);
    checkOutput("stream_pops", pops, 32'd32);
    checkOutput("stream_latency", first_valid - first_rd, 32'd2);
    checkOutput("stream_rate", last_pop - first_pop, 32'd31);

    // Backpressure: buffer fills to two and reads stop.
    doReset();
    for (int i = 0; i < 8; i++) writeWord(i, 1'b0);
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("bp_occ", {30'd0, occupancy}, 32'd2);
    checkOutput("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("bp_head", out_data, 32'd0);
    checkOutput("bp_fifo_left", fq.size(), 32'd6);
    out_ready = 1'b1;
    drain(50, 1'b0);
    checkOutput("bp_pops", pops, 32'd8);

    // Toggling ready.
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      writeWord(32'h100 + i, ~out_ready);
    end
    drain(100, 1'b1);
    checkOutput("toggle_pops", pops, 32'd16);

    // Burst boundaries over 12 beats, then a reset mid-burst.
    doReset();
    for (int i = 0; i < 12; i++) writeWord(32'h200 + i, 1'b1);
    drain(50, 1'b0);
`ifdef RD_STREAM_LAST_EN
    checkOutput("last_count_12", last_cnt, 32'd3);
`else
    checkOutput("last_count_12", last_cnt, 32'd0);
`endif
    doReset();
    for (int i = 0; i < 5; i++) writeWord(32'h300 + i, 1'b1);
    drain(50, 1'b0);
    doReset();
    for (int i = 0; i < 4; i++) writeWord(32'h400 + i, 1'b1);
    drain(50, 1'b0);
`ifdef RD_STREAM_LAST_EN
    checkOutput("last_after_reset", last_cnt, 32'd1);
`else
    checkOutput("last_after_reset", last_cnt, 32'd0);
`endif

    checkOutput("fifo_underflow", uf_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
